// File: rtl/reg_wb_pkg.sv
// Shared constants, write-back state encoding and round-robin pointer helper
// for the register-bank write-back arbiter.
package reg_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int ZERO_REG   = 0;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_WRITE = 1'b1
    } wb_state_e;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/reg_wb_rr_arbiter.sv
// Combinational rotating-priority arbiter: first set request at or above start_ptr, wrapping.
// REG_WB_FIXED_PRIO_EN forces the scan to start at index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    int               idx;
    logic [IDX_W-1:0] sel;

`ifdef REG_WB_FIXED_PRIO_EN
    logic unused_start_ptr;
    assign unused_start_ptr = ^start_ptr;
`endif

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef REG_WB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(start_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
            sel = IDX_W'(idx);
            if (!grant_vld && req[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the register bank's single write port: one grant per cycle,
// one-deep output stage, RAW hazard flags. REG_WB_FIXED_PRIO_EN selects fixed priority.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      stall_in,
    input  logic [ADDR_W-1:0]         rd_addr_1,
    input  logic [ADDR_W-1:0]         rd_addr_2,
    output logic                      hazard_1,
    output logic                      hazard_2,
    output logic                      we,
    output logic [ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic [IDX_W-1:0]          grant_id
);

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_arr;
    logic [NUM_REQ-1:0]             win_oh;
    logic [IDX_W-1:0]               win_idx;
    logic [IDX_W-1:0]               rr_ptr;
    logic                           win_vld;
    logic                           handshake;
    wb_state_e                      state_q, state_d;

    assign addr_arr = req_addr;
    assign data_arr = req_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req       (req_valid),
        .start_ptr (rr_ptr),
        .grant     (win_oh),
        .grant_idx (win_idx),
        .grant_vld (win_vld)
    );

    // Reset also gates ready so nothing is consumed while the bank port is being cleared.
    assign handshake = win_vld & ~stall_in & ~reset;
    assign req_ready = handshake ? win_oh : '0;

`ifdef REG_WB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          rr_ptr <= '0;
        else if (handshake) rr_ptr <= IDX_W'(rr_next(32'(win_idx), NUM_REQ));
    end
`endif

    // Register 0 is hard-wired, so a write to it is consumed without raising we.
    always_comb begin
        state_d = WB_IDLE;
        if (handshake && addr_arr[win_idx] != ADDR_W'(ZERO_REG)) state_d = WB_WRITE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= WB_IDLE;
        else       state_q <= state_d;
    end

    assign we = (state_q == WB_WRITE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_reg  <= '0;
            write_data <= '0;
            grant_id   <= '0;
        end else if (handshake) begin
            write_reg  <= addr_arr[win_idx];
            write_data <= data_arr[win_idx];
            grant_id   <= win_idx;
        end
    end

    // Any pending request counts, granted or not, so decode never reads a stale value.
    always_comb begin
        hazard_1 = we && (write_reg == rd_addr_1);
        hazard_2 = we && (write_reg == rd_addr_2);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && addr_arr[i] == rd_addr_1) hazard_1 = 1'b1;
            if (req_valid[i] && addr_arr[i] == rd_addr_2) hazard_2 = 1'b1;
        end
        if (rd_addr_1 == ADDR_W'(ZERO_REG)) hazard_1 = 1'b0;
        if (rd_addr_2 == ADDR_W'(ZERO_REG)) hazard_2 = 1'b0;
    end

endmodule
